// File: rtl/hwag_sync_ctrl.sv
// hwag_sync_ctrl: crank-wheel synchroniser for a missing-tooth wheel.
// Measures tooth-to-tooth periods, finds the gap (a period more than twice
// the previous one), then tracks the tooth index and flags any tooth/gap
// pattern that disagrees with the wheel geometry.
// Debug state encoding on state_dbg: 0=IDLE, 1=ARM, 2=SEARCH, 3=SYNC.
module hwag_sync_ctrl #(
    parameter int WIDTH      = 24,
    parameter int TCNT_WIDTH = 6,
    parameter int TOOTH_LAST = 57
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  ena,
    input  logic                  cap,
    input  logic                  clr_err,
    output logic [WIDTH-1:0]      pcnt,
    output logic [WIDTH-1:0]      last_period,
    output logic [TCNT_WIDTH-1:0] tooth,
    output logic                  gap,
    output logic                  synced,
    output logic                  sync_err,
    output logic                  ovf,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_SEARCH = 2'd2,
        ST_SYNC   = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0]      PMAX  = '1;
    localparam logic [TCNT_WIDTH-1:0] TLAST = TCNT_WIDTH'(TOOTH_LAST);

    state_t                r_state;
    logic [WIDTH-1:0]      r_pcnt;
    logic [WIDTH-1:0]      r_last_period;
    logic [WIDTH-1:0]      r_prev;
    logic [TCNT_WIDTH-1:0] r_tooth;
    logic                  r_gap;
    logic                  r_synced;
    logic                  r_sync_err;
    logic                  r_ovf;
    // High when pcnt was already all-ones in the previous clk, so the
    // saturation event fires only once per stall and clr_err can clear ovf
    // while the counter is still parked at all-ones.
    logic                  r_sat_done;

    logic                  w_cap;
    logic                  w_pcnt_max;
    logic [WIDTH-1:0]      w_period;
    logic                  w_sat;
    logic                  w_gap_cond;
    logic                  w_at_last;
    logic                  w_set_sync_err;

    // Derived per-clk decisions: accepted cap, period, saturation, gap test.
    always_comb begin
        w_cap      = cap && (r_state != ST_IDLE);
        w_pcnt_max = (r_pcnt == PMAX);
        w_period   = w_pcnt_max ? PMAX : (r_pcnt + WIDTH'(1));
        w_sat      = w_pcnt_max && !r_sat_done;
        // Compared one bit wider so 2*prev cannot wrap.
        w_gap_cond = ({1'b0, w_period} > {r_prev, 1'b0});
        w_at_last  = (r_tooth == TLAST);
        // A mismatch is a gap where a tooth belongs or a tooth where the gap belongs.
        w_set_sync_err = ena && !w_sat && w_cap && (r_state == ST_SYNC) &&
                         (w_at_last ? !w_gap_cond : w_gap_cond);
    end

    // Period counter, sync FSM and sticky flags, all registered.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state       <= ST_IDLE;
            r_pcnt        <= '0;
            r_last_period <= '0;
            r_prev        <= '0;
            r_tooth       <= '0;
            r_gap         <= 1'b0;
            r_synced      <= 1'b0;
            r_sync_err    <= 1'b0;
            r_ovf         <= 1'b0;
            r_sat_done    <= 1'b0;
        end else if (!ena) begin
            // Disabled: park in IDLE; last_period, prev and flags keep their values.
            r_state    <= ST_IDLE;
            r_pcnt     <= '0;
            r_tooth    <= '0;
            r_gap      <= 1'b0;
            r_synced   <= 1'b0;
            r_sat_done <= 1'b0;
        end else begin
            r_gap <= 1'b0;

            // Counter: restart on an accepted cap, otherwise saturating count.
            if (w_cap) begin
                r_pcnt        <= '0;
                r_last_period <= w_period;
            end else begin
                r_pcnt <= w_period;
            end
            r_sat_done <= w_pcnt_max && !w_cap;

            if (w_sat) begin
                // Lost the wheel: restart acquisition regardless of cap.
                r_state  <= ST_ARM;
                r_tooth  <= '0;
                r_synced <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_ARM;
                    end
                    ST_ARM: begin
                        // First period after arming may be partial: use it only as reference.
                        if (w_cap) begin
                            r_prev  <= w_period;
                            r_state <= ST_SEARCH;
                        end
                    end
                    ST_SEARCH: begin
                        if (w_cap) begin
                            if (w_gap_cond) begin
                                r_state  <= ST_SYNC;
                                r_tooth  <= '0;
                                r_gap    <= 1'b1;
                                r_synced <= 1'b1;
                            end else begin
                                r_prev <= w_period;
                            end
                        end
                    end
                    ST_SYNC: begin
                        if (w_cap) begin
                            if (!w_at_last) begin
                                if (w_gap_cond) begin
                                    r_state  <= ST_SEARCH;
                                    r_tooth  <= '0;
                                    r_synced <= 1'b0;
                                end else begin
                                    r_tooth <= r_tooth + TCNT_WIDTH'(1);
                                    r_prev  <= w_period;
                                end
                            end else begin
                                if (w_gap_cond) begin
                                    r_tooth <= '0;
                                    r_gap   <= 1'b1;
                                end else begin
                                    r_state  <= ST_SEARCH;
                                    r_tooth  <= '0;
                                    r_synced <= 1'b0;
                                    r_prev   <= w_period;
                                end
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end

            // Sticky flags: a setting event beats a simultaneous clear.
            if (w_set_sync_err) begin
                r_sync_err <= 1'b1;
            end else if (clr_err) begin
                r_sync_err <= 1'b0;
            end
            if (w_sat) begin
                r_ovf <= 1'b1;
            end else if (clr_err) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign pcnt        = r_pcnt;
    assign last_period = r_last_period;
    assign tooth       = r_tooth;
    assign gap         = r_gap;
    assign synced      = r_synced;
    assign sync_err    = r_sync_err;
    assign ovf         = r_ovf;
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_hwag_sync_ctrl.sv
// Bench for hwag_sync_ctrl with an 8-bit counter and a 4-tooth revolution.
// Every driven clk pushes the model's expected outputs; a monitor pops one
// entry per clk after the edge and compares. Directed checks against fixed
// values mark the key moments of each scenario.
module tb_hwag_sync_ctrl;

  localparam int W     = 8;
  localparam int TW    = 6;
  localparam int TLAST = 3;
  localparam int MAXV  = 255;

  localparam int M_IDLE   = 0;
  localparam int M_ARM    = 1;
  localparam int M_SEARCH = 2;
  localparam int M_SYNC   = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic srst = 1'b0, ena = 1'b0, cap = 1'b0, clr_err = 1'b0;
  logic [W-1:0]  pcnt, last_period;
  logic [TW-1:0] tooth;
  logic          gap, synced, sync_err, ovf;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  hwag_sync_ctrl #(.WIDTH(W), .TCNT_WIDTH(TW), .TOOTH_LAST(TLAST)) dut (
    .clk(clk), .srst(srst), .ena(ena), .cap(cap), .clr_err(clr_err),
    .pcnt(pcnt), .last_period(last_period), .tooth(tooth), .gap(gap),
    .synced(synced), .sync_err(sync_err), .ovf(ovf), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [27:0] exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;

  // Reference model: ticks counts clks since the last accepted cap without
  // bound; pcnt is its clamp, and saturation is the clk where it equals MAXV.
  int m_st, m_ticks, m_lp, m_prev, m_tooth;
  bit m_gap, m_se, m_ovf;

  function automatic int clamp(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic model_step(input bit s, input bit e, input bit c, input bit k);
    int per;
    bit capa, sat, big, gap_expected, set_se;
    logic [27:0] v;
    if (s) begin
      m_st = M_IDLE; m_ticks = 0; m_lp = 0; m_prev = 0; m_tooth = 0;
      m_gap = 0; m_se = 0; m_ovf = 0;
    end else if (!e) begin
      m_st = M_IDLE; m_ticks = 0; m_tooth = 0; m_gap = 0;
    end else begin
      capa   = c && (m_st != M_IDLE);
      per    = clamp(m_ticks + 1);
      sat    = (m_ticks == MAXV);
      big    = (per > 2 * m_prev);
      set_se = 0;
      m_gap  = 0;
      if (capa) m_lp = per;
      if (sat) begin
        m_st = M_ARM; m_tooth = 0;
      end else if (m_st == M_IDLE) begin
        m_st = M_ARM;
      end else if (capa) begin
        if (m_st == M_ARM) begin
          m_prev = per; m_st = M_SEARCH;
        end else if (m_st == M_SEARCH) begin
          if (big) begin m_st = M_SYNC; m_tooth = 0; m_gap = 1; end
          else m_prev = per;
        end else begin
          // Wheel geometry: the gap belongs right after tooth TLAST and nowhere else.
          gap_expected = (m_tooth == TLAST);
          if (big == gap_expected) begin
            if (big) begin m_tooth = 0; m_gap = 1; end
            else begin m_tooth = m_tooth + 1; m_prev = per; end
          end else begin
            set_se = 1; m_st = M_SEARCH; m_tooth = 0;
            if (!big) m_prev = per;
          end
        end
      end
      m_ticks = capa ? 0 : m_ticks + 1;
      if (sat) m_ovf = 1; else if (k) m_ovf = 0;
      if (set_se) m_se = 1; else if (k) m_se = 0;
    end
    v = {2'(m_st), 8'(clamp(m_ticks)), 8'(m_lp), 6'(m_tooth),
         m_gap, (m_st == M_SYNC), m_se, m_ovf};
    exp_q.push_back(v);
  endtask

  // Monitor: one expected entry per clk, compared just after the edge.
  always @(posedge clk) begin
    logic [27:0] act, expv;
    #1;
    if (mon_en) begin
      act = {state_dbg, pcnt, last_period, tooth, gap, synced, sync_err, ovf};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL cycle_cmp t=%0t: got %h with no expected entry queued", $time, act);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          n_err++;
          $display("FAIL cycle_cmp t=%0t: got st=%0d pcnt=%0d lp=%0d tooth=%0d gap=%0b syn=%0b se=%0b ovf=%0b, expected st=%0d pcnt=%0d lp=%0d tooth=%0d gap=%0b syn=%0b se=%0b ovf=%0b",
                   $time, act[27:26], act[25:18], act[17:10], act[9:4], act[3], act[2], act[1], act[0],
                   expv[27:26], expv[25:18], expv[17:10], expv[9:4], expv[3], expv[2], expv[1], expv[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit s, input bit e, input bit c, input bit k);
    @(negedge clk);
    srst = s; ena = e; cap = c; clr_err = k;
    model_step(s, e, c, k);
    mon_en = 1'b1;
  endtask

  // One tooth interval of iv clks, cap on the last clk.
  task automatic tooth_iv(input int iv, input bit clr_on_cap);
    for (int i = 0; i < iv - 1; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, clr_on_cap);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, act, expv);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r, sel, iv;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    settle();
    chk("rst_pcnt", int'(pcnt), 0);
    chk("rst_last_period", int'(last_period), 0);
    chk("rst_tooth", int'(tooth), 0);
    chk("rst_flags", int'({gap, synced, sync_err, ovf}), 0);
    chk("rst_state", int'(state_dbg), M_IDLE);

    // Lock: regular 10-clk teeth then a 30-clk gap
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tooth_iv(10, 1'b0);
    settle();
    chk("lock_lp10", int'(last_period), 10);
    chk("lock_search", int'(state_dbg), M_SEARCH);
    tooth_iv(30, 1'b0);
    settle();
    chk("lock_lp30", int'(last_period), 30);
    chk("lock_gap", int'(gap), 1);
    chk("lock_synced", int'(synced), 1);
    chk("lock_tooth", int'(tooth), 0);

    // Steady rotation: three revolutions
    for (int rev = 0; rev < 3; rev++) begin
      for (int t = 1; t <= TLAST; t++) begin
        tooth_iv(10, 1'b0);
        settle();
        chk("rot_tooth", int'(tooth), t);
        chk("rot_nogap", int'(gap), 0);
      end
      tooth_iv(30, 1'b0);
      settle();
      chk("rot_wrap_tooth", int'(tooth), 0);
      chk("rot_gap", int'(gap), 1);
      chk("rot_no_err", int'(sync_err), 0);
    end

    // Early gap at tooth 1
    tooth_iv(10, 1'b0);
    tooth_iv(30, 1'b0);
    settle();
    chk("early_err", int'(sync_err), 1);
    chk("early_synced", int'(synced), 0);
    chk("early_state", int'(state_dbg), M_SEARCH);
    chk("early_tooth", int'(tooth), 0);

    // Relock, clear the flag, then a missing gap with clr_err on the same clk
    tooth_iv(10, 1'b0);
    tooth_iv(30, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    chk("clr_sync_err", int'(sync_err), 0);
    tooth_iv(9, 1'b0);
    tooth_iv(10, 1'b0);
    tooth_iv(10, 1'b0);
    settle();
    chk("miss_at_last", int'(tooth), TLAST);
    tooth_iv(10, 1'b1);
    settle();
    chk("miss_err_set_wins", int'(sync_err), 1);
    chk("miss_synced", int'(synced), 0);
    chk("miss_state", int'(state_dbg), M_SEARCH);

    // Cap landing in the saturation clk
    tooth_iv(256, 1'b0);
    settle();
    chk("satcap_lp", int'(last_period), MAXV);
    chk("satcap_pcnt", int'(pcnt), 0);
    chk("satcap_ovf", int'(ovf), 1);
    chk("satcap_state", int'(state_dbg), M_ARM);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    chk("satcap_clr_ovf", int'(ovf), 0);

    // Stall: 300 clks with no cap
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("stall_pcnt", int'(pcnt), MAXV);
    chk("stall_ovf", int'(ovf), 1);
    chk("stall_state", int'(state_dbg), M_ARM);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    chk("stall_clr_ovf", int'(ovf), 0);

    // Reacquire, raise sync_err, reacquire again, then srst mid-SYNC
    tooth_iv(10, 1'b0);
    tooth_iv(10, 1'b0);
    tooth_iv(10, 1'b0);
    tooth_iv(30, 1'b0);
    tooth_iv(10, 1'b0);
    tooth_iv(30, 1'b0);
    tooth_iv(10, 1'b0);
    tooth_iv(30, 1'b0);
    tooth_iv(10, 1'b0);
    settle();
    chk("pre_rst_synced", int'(synced), 1);
    chk("pre_rst_err", int'(sync_err), 1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    chk("midrst_outputs", int'({pcnt, last_period, tooth, gap, synced, sync_err, ovf}), 0);
    chk("midrst_state", int'(state_dbg), M_IDLE);

    // Randomized traffic against the model
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end else if (r < 8) begin
        repeat ($urandom_range(1, 3))
          step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        sel = int'($urandom_range(0, 9));
        if (sel < 6)      iv = 10;
        else if (sel < 8) iv = 30;
        else if (sel < 9) iv = int'($urandom_range(1, 40));
        else              iv = int'($urandom_range(250, 260));
        for (int i = 0; i < iv - 1; i++)
          step(1'b0, 1'b1, 1'b0, ($urandom_range(0, 15) == 0));
        step(1'b0, 1'b1, 1'b1, ($urandom_range(0, 7) == 0));
      end
    end

    settle();
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
